uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter between `N_REQ` byte producers (CPU console, debug monitor, boot loader). It accepts one byte at a time from the granted requester, drives the transmitter's `sendData`/`sendReq` pair and uses the transmitter's `ready` to sequence each byte. Optional per-requester lock keeps multi-byte messages from interleaving. It sits between the requesters and `uart` in the 12 MHz domain.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `IDX_W`, default 2: width of grant index; must equal ceil(log2(N_REQ)).

- `clk12MHz`  in  1: system clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: bit i = requester i has a byte on its slice of `req_data`.
- `req_data`  in  8*N_REQ: byte for requester i at bits [8i+7:8i].
- `req_lock`  in  N_REQ: bit i high = keep grant on requester i between bytes.
- `req_ready`  out  N_REQ: one-hot, 1-cycle accept pulse; byte taken when `req_valid[i] & req_ready[i]`.
- `uart_send_data`  out  8: byte to the transmitter.
- `uart_send_req`  out  1: send request to the transmitter.
- `uart_ready`  in  1: transmitter ready (registered; drops the cycle after a request is sampled, stays low until the frame, stop bit included, ends).
- `grant_id`  out  IDX_W: index of current/last granted requester.
- `busy`  out  1: high whenever state is not IDLE.

## Operation
- States: DRAIN, IDLE, ISSUE, WAIT.
- DRAIN: `uart_send_req`=0; go to IDLE on first cycle `uart_ready`=1. Guarantees no byte is issued into a frame still in flight after reset.
- IDLE: if `uart_ready`=1 and a candidate exists, grant it: `req_ready[g]`=1 this cycle, latch `req_data[g]` into `uart_send_data`, `grant_id`<=g, pointer<=g, next state ISSUE.
- Candidate selection: if locked (previous grant g has `req_lock[g]`=1), only g is eligible; if `req_valid[g]`=0, stay in IDLE with no grant (others starve while lock held). Otherwise round-robin over `req_valid`, searching from pointer+1 upward with wrap modulo N_REQ; the pointer itself is lowest priority.
- Lock evaluated in IDLE each cycle; dropping `req_lock[g]` releases immediately to round-robin.
- ISSUE: `uart_send_req`=1. When `uart_ready`=0 is sampled, go to WAIT.
- WAIT: `uart_send_req`=0. When `uart_ready`=1, go to IDLE.
- `uart_send_req` must be low before the frame ends, so the transmitter never re-arms on a stale request.
- `req_ready` is never high outside IDLE; at most one bit set.
- `uart_send_data` holds its value from latch until the next grant.

## Timing
- Reset values: state DRAIN, pointer N_REQ-1 (requester 0 wins first), lock inactive, `req_ready`=0, `uart_send_req`=0, `uart_send_data`=0x00, `grant_id`=0, `busy`=1.
- `uart_send_req`, `busy` decoded from state; `req_ready` combinational in IDLE from registered state/pointer and inputs `req_valid`, `req_lock`, `uart_ready`.
- Accept (cycle T) -> `uart_send_req` high at T+1; with a conforming transmitter `uart_ready` low at T+2, ISSUE lasts 2 cycles, WAIT from T+3.
- Back-to-back: byte n+1 accepted the first cycle after `uart_ready` returns high plus one IDLE cycle; minimum gap between frames set by the transmitter only.
- Reset asserted in any state: next cycle DRAIN; byte in flight in the transmitter completes; accepted but unissued byte is lost.
- `req_valid` dropping after grant has no effect; the byte is already latched.

## Test plan
- Reset release with `uart_ready` held 0 for 50 cycles, `req_valid`=0001 -> no `req_ready`, no `uart_send_req` until `uart_ready`=1; then accept byte 0x41 from req 0 exactly one cycle later.
- Single byte: `req_valid[2]`=1, data 0x5A -> `req_ready`=0100 one cycle, `uart_send_req` high for 2 cycles, tx line shows 0x5A frame, `busy` low one cycle after `uart_ready` returns.
- Round robin: all four valid continuously, distinct bytes -> grant order 0,1,2,3,0,1; no requester granted twice while another waits.
- Lock: req 1 with `req_lock[1]`=1 sends 3 bytes, its valid gaps 100 cycles between bytes, req 0/3 valid throughout -> 3 consecutive grants to 1; after lock drops next grant is 2? no: next valid after 1, i.e. 3, then 0.
- Reset mid-frame: assert `reset` while WAIT with frame half sent -> frame completes intact on tx, arbiter holds in DRAIN, next pending byte starts only after `uart_ready`=1.
- `req_valid` deasserted the cycle after accept -> byte still transmitted once, no second `req_ready` pulse.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// master = requesters plus transmitter (drive valid/data/lock/uart_ready); slave = arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_lock;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         uart_send_data;
    logic               uart_send_req;
    logic               uart_ready;
    logic [IDX_W-1:0]   grant_id;
    logic               busy;

    modport master (
        output req_valid, req_data, req_lock, uart_ready,
        input  req_ready, uart_send_data, uart_send_req, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, req_lock, uart_ready,
        output req_ready, uart_send_data, uart_send_req, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin (with optional per-requester lock) sharing of one UART transmitter.
// Accept in IDLE -> send request next cycle; requesters stall until the transmitter frame ends.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic              clk12MHz,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic             have_grant;
    logic [7:0]       send_data;
    logic [IDX_W-1:0] grant_idx;

    logic             cand_found;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] probe;
    logic [7:0]       cand_data;
    logic             grant;
    logic [N_REQ-1:0] ready_vec;

    // A held lock pins eligibility to the last grantee; otherwise scan from
    // farthest to nearest so the requester just after the pointer wins.
    always_comb begin
        cand_found = 1'b0;
        cand       = ptr;
        probe      = '0;
        if (have_grant && bus.req_lock[ptr]) begin
            cand_found = bus.req_valid[ptr];
        end else begin
            for (int k = N_REQ; k >= 1; k--) begin
                probe = IDX_W'((int'(ptr) + k) % N_REQ);
                if (bus.req_valid[probe]) begin
                    cand_found = 1'b1;
                    cand       = probe;
                end
            end
        end
    end

    always_comb begin
        cand_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cand == IDX_W'(i)) begin
                cand_data = bus.req_data[8*i +: 8];
            end
        end
    end

    assign grant = (state == IDLE) && bus.uart_ready && cand_found;

    always_comb begin
        ready_vec = '0;
        if (grant) begin
            ready_vec[cand] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DRAIN:   if (bus.uart_ready)  state_nxt = IDLE;
            IDLE:    if (grant)           state_nxt = ISSUE;
            ISSUE:   if (!bus.uart_ready) state_nxt = WAIT;
            WAIT:    if (bus.uart_ready)  state_nxt = IDLE;
            default:                      state_nxt = DRAIN;
        endcase
    end

    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state      <= DRAIN;
            ptr        <= IDX_W'(N_REQ - 1);
            have_grant <= 1'b0;
            send_data  <= 8'h00;
            grant_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                ptr        <= cand;
                have_grant <= 1'b1;
                send_data  <= cand_data;
                grant_idx  <= cand;
            end
        end
    end

    assign bus.req_ready      = ready_vec;
    assign bus.uart_send_data = send_data;
    assign bus.uart_send_req  = (state == ISSUE);
    assign bus.grant_id       = grant_idx;
    assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter with a transaction-level arbitration model.
// A simple transmitter model drives uart_ready and records every byte it sends.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk12MHz = 1'b0;
    logic reset;
    always #5 clk12MHz = ~clk12MHz;

    uart_tx_arbiter_if #(.N_REQ(N), .IDX_W(2)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .IDX_W(2)) dut (
        .clk12MHz (clk12MHz),
        .reset    (reset),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    // requester side
    logic [7:0]   base [N];
    int           rem  [N];
    logic [N-1:0] en;
    logic [N-1:0] lck;
    logic [N-1:0] acc_mask = '0;

    // observation
    int   obs_q [$];
    int   rr_cnt = 0;
    int   sreq_cnt = 0;
    int   last_rr_cyc = 0;
    logic s_req = 1'b0;
    logic [7:0] s_data = 8'h00;

    // transmitter model
    logic tx_rdy = 1'b1;
    logic tx_hold = 1'b1;
    int   tx_cnt = 0;
    int   frame_len = 12;
    logic [7:0] tx_log [$];
    assign bus.uart_ready = tx_rdy & ~tx_hold;

    // arbitration model
    logic       m_armed = 1'b0;
    logic       m_req_out = 1'b0;
    logic       m_have = 1'b0;
    int         m_last = N - 1;
    logic [7:0] m_data = 8'h00;
    int         m_gid = 0;
    logic [7:0] exp_q [$];

    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
    int lk_exp [5] = '{1, 1, 1, 3, 0};

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Who should win given the rules: a held lock pins the last grantee,
    // otherwise first valid requester after the last grantee, wrapping.
    function automatic int pick(logic [N-1:0] v, logic [N-1:0] l, logic have, int last);
        if (have && l[last]) return v[last] ? last : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int idx_of(logic [N-1:0] oh);
        for (int i = 0; i < N; i++) if (oh[i]) return i;
        return -1;
    endfunction

    always @(posedge clk12MHz) cyc <= cyc + 1;

    always @(posedge clk12MHz) begin
        if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_rdy <= 1'b1;
        end else if (bus.uart_ready && s_req) begin
            tx_rdy <= 1'b0;
            tx_cnt <= frame_len;
            tx_log.push_back(s_data);
        end
    end

    always @(negedge clk12MHz) begin
        int c;
        logic [N-1:0] er;
        c  = pick(bus.req_valid, bus.req_lock, m_have, m_last);
        er = '0;
        if (m_armed && bus.uart_ready && c >= 0) er = N'(1) << c;

        acc_mask = bus.req_ready & bus.req_valid;
        if (bus.req_ready != '0) begin
            obs_q.push_back(idx_of(bus.req_ready));
            rr_cnt++;
            last_rr_cyc = cyc;
        end
        if (bus.uart_send_req) sreq_cnt++;
        s_req  = bus.uart_send_req;
        s_data = bus.uart_send_data;

        if (chk_en) begin
            check("req_ready", 32'(bus.req_ready), 32'(er));
            check("uart_send_req", 32'(bus.uart_send_req), 32'(m_req_out));
            check("busy", 32'(bus.busy), 32'(!m_armed));
            check("uart_send_data", 32'(bus.uart_send_data), 32'(m_data));
            check("grant_id", 32'(bus.grant_id), 32'(m_gid));
        end

        if (reset) begin
            m_armed = 1'b0; m_req_out = 1'b0; m_have = 1'b0;
            m_last = N - 1; m_data = 8'h00; m_gid = 0;
        end else if (m_armed) begin
            if (er != '0) begin
                m_armed   = 1'b0;
                m_req_out = 1'b1;
                m_data    = bus.req_data[8*c +: 8];
                m_gid     = c;
                m_last    = c;
                m_have    = 1'b1;
                exp_q.push_back(m_data);
            end
        end else if (m_req_out) begin
            if (!bus.uart_ready) m_req_out = 1'b0;
        end else if (bus.uart_ready) begin
            m_armed = 1'b1;
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]        = en[i] && (rem[i] > 0);
            bus.req_data[8*i +: 8]  = base[i];
            bus.req_lock[i]         = lck[i];
        end
    endtask

    task automatic step();
        @(posedge clk12MHz);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                rem[i]--;
                base[i]++;
            end
        end
        drive();
    endtask

    task automatic wait_grant(string name);
        int start = rr_cnt;
        int n = 0;
        while (rr_cnt == start && n < 1000) begin
            step();
            n++;
        end
        if (rr_cnt == start) check({name, "_grant_timeout"}, 32'(1), 32'(0));
    endtask

    task automatic wait_quiet(string name);
        int n = 0;
        int calm = 0;
        while (calm < 3 && n < 5000) begin
            step();
            n++;
            if (bus.req_valid == '0 && !bus.busy && tx_cnt == 0 && bus.uart_ready) calm++;
            else calm = 0;
        end
        if (calm < 3) check({name, "_quiet_timeout"}, 32'(1), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;
        int rr0;
        int n;
        reset = 1'b1;
        en    = '1;
        lck   = '0;
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            base[i] = 8'(16 * i + 1);
        end
        base[0] = 8'h41;
        rem[0]  = 1;
        drive();
        repeat (3) step();
        chk_en = 1'b1;

        // reset values
        @(negedge clk12MHz);
        check("rst_busy", 32'(bus.busy), 32'(1));
        check("rst_send_req", 32'(bus.uart_send_req), 32'(0));
        check("rst_send_data", 32'(bus.uart_send_data), 32'(0));
        check("rst_grant_id", 32'(bus.grant_id), 32'(0));
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        step();
        reset = 1'b0;

        // transmitter not ready after reset: nothing may be accepted
        rr_cnt = 0; sreq_cnt = 0; obs_q.delete();
        repeat (50) step();
        check("drain_no_ready", 32'(rr_cnt), 32'(0));
        check("drain_no_req", 32'(sreq_cnt), 32'(0));
        tx_hold = 1'b0;
        rel = cyc;
        wait_grant("drain");
        check("drain_release_latency", 32'(last_rr_cyc - rel), 32'(1));
        check("drain_first_winner", 32'(obs_q[0]), 32'(0));
        check("drain_first_byte", 32'(bus.uart_send_data), 32'(8'h41));
        wait_quiet("drain");

        // single byte from requester 2
        obs_q.delete(); rr_cnt = 0; sreq_cnt = 0;
        base[2] = 8'h5A; rem[2] = 1;
        wait_grant("single");
        wait_quiet("single");
        check("single_pulses", 32'(rr_cnt), 32'(1));
        check("single_winner", 32'(obs_q[0]), 32'(2));
        check("single_req_cycles", 32'(sreq_cnt), 32'(2));
        check("single_tx_byte", 32'(tx_log[$]), 32'(8'h5A));

        // park pointer on 3, then all four contend
        rem[3] = 1;
        wait_grant("park");
        wait_quiet("park");
        obs_q.delete();
        base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
        rem[0] = 2; rem[1] = 2; rem[2] = 1; rem[3] = 1;
        wait_quiet("rr");
        check("rr_count", 32'(obs_q.size()), 32'(6));
        for (int i = 0; i < 6 && i < obs_q.size(); i++) check("rr_order", 32'(obs_q[i]), 32'(rr_exp[i]));

        // lock holds requester 1 across long gaps while 0 and 3 wait
        obs_q.delete();
        lck[1] = 1'b1; rem[1] = 1;
        wait_grant("lock1");
        rem[0] = 1; rem[3] = 1;
        repeat (100) step();
        rem[1] = 1;
        wait_grant("lock2");
        repeat (100) step();
        rem[1] = 1;
        wait_grant("lock3");
        lck[1] = 1'b0;
        wait_quiet("lock");
        check("lock_count", 32'(obs_q.size()), 32'(5));
        for (int i = 0; i < 5 && i < obs_q.size(); i++) check("lock_order", 32'(obs_q[i]), 32'(lk_exp[i]));

        // valid withdrawn right after accept
        rr_cnt = 0;
        base[3] = 8'hE7; rem[3] = 3;
        wait_grant("withdraw");
        rem[3] = 0;
        drive();
        wait_quiet("withdraw");
        check("withdraw_pulses", 32'(rr_cnt), 32'(1));
        check("withdraw_tx_byte", 32'(tx_log[$]), 32'(8'hE7));

        // reset with a frame half sent, another byte pending
        base[0] = 8'hC3; rem[0] = 1;
        wait_grant("midrst");
        n = 0;
        while (tx_cnt != frame_len / 2 && n < 200) begin step(); n++; end
        check("midrst_in_frame", 32'(tx_cnt), 32'(frame_len / 2));
        base[2] = 8'h77; rem[2] = 1;
        drive();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rr0 = rr_cnt;
        n = 0;
        while (tx_cnt > 0 && n < 200) begin step(); n++; end
        check("midrst_hold_until_ready", 32'(rr_cnt - rr0), 32'(0));
        wait_quiet("midrst");
        check("midrst_frame_intact", 32'(tx_log[tx_log.size()-2]), 32'(8'hC3));
        check("midrst_next_byte", 32'(tx_log[$]), 32'(8'h77));

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 15) == 0) rem[i] = int'($urandom_range(1, 4));
                if ($urandom_range(0, 31) == 0) en[i] = ~en[i];
                if ($urandom_range(0, 63) == 0) lck[i] = ~lck[i];
                if ($urandom_range(0, 7) == 0) base[i] = 8'($urandom);
            end
            if (k % 500 == 0) frame_len = int'($urandom_range(3, 20));
            step();
        end
        lck = '0; en = '1;
        for (int i = 0; i < N; i++) rem[i] = 0;
        wait_quiet("random");

        // every accepted byte leaves the transmitter exactly once, in order
        check("tx_byte_count", 32'(tx_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < tx_log.size() && i < exp_q.size(); i++) begin
            check("tx_byte", 32'(tx_log[i]), 32'(exp_q[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
